bat_amateur_loader: RTL and testbench

- Synthesizable program loader/monitor that replaces the hand-written stimulus driving bat_amateur's external RAM port.
- Holds the CPU in HALT and writes a program image into external RAM over the shared bus, optionally reads it back to verify, then releases the CPU.
- While the CPU runs, it captures every change on the CPU OUT bus into a readable log FIFO, and ends on a CPU halt or a cycle timeout.
- Data width, address width, image length, load base and log depth are parametrised.

---
 rtl/bat_amateur_loader.sv | 262 ++++++++++++++++++++++++++
 tb/tb_bat_amateur_loader.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bat_amateur_loader.sv
// bat_amateur_loader
//   Program loader and run monitor for the bat_amateur CPU. While the CPU is
//   held in HALT it writes a program image into external RAM over the shared
//   bus, optionally reads the image back to verify it, then releases the CPU.
//   While the CPU runs, every change on its OUT bus is pushed into a
//   show-ahead log FIFO. The run ends on a CPU halt or on a cycle timeout.
//
// Ports
//   CLK, RST          clock, asynchronous active-high reset
//   START             one-cycle start pulse (accepted in IDLE, DONE, ERROR)
//   VERIFY_EN         sampled with START: add the read-back pass
//   PROG_LEN          sampled with START: number of image words (0 = run only)
//   PROG_ADDR         index into the image source
//   PROG_DATA         image word at PROG_ADDR (combinational source)
//   HALT              1 holds the CPU stopped
//   EXT_RAM_EN        1 gives the loader ownership of the RAM port
//   EXT_RAM_RW        1 = write, 0 = read
//   ADDRESS           RAM address
//   BUS_OUT, BUS_OE   write data and its drive enable
//   BUS_IN            data bus as read (RAM read latency 1 cycle)
//   CPU_OUT           CPU output bus
//   CPU_HALTED        CPU has executed its halt instruction
//   LOG_RD            pop one log entry
//   LOG_DATA          head of the log FIFO
//   LOG_EMPTY         log FIFO empty
//   LOG_OVF           sticky: a capture was dropped because the log was full
//   BUSY, DONE, ERROR state flags
//   TIMEOUT           run ended on the cycle limit
//   ERR_ADDR          first mismatching RAM address of the verify pass
module bat_amateur_loader #(
   parameter int                       DATA_WIDTH    = 16,
   parameter int                       ADDRESS_WIDTH = 16,
   parameter int                       LEN_WIDTH     = 8,
   parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = '0,
   parameter int                       LOG_DEPTH     = 16,
   parameter int                       RUN_LIMIT     = 65535
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     START,
   input  logic                     VERIFY_EN,
   input  logic [LEN_WIDTH-1:0]     PROG_LEN,
   output logic [LEN_WIDTH-1:0]     PROG_ADDR,
   input  logic [DATA_WIDTH-1:0]    PROG_DATA,
   output logic                     HALT,
   output logic                     EXT_RAM_EN,
   output logic                     EXT_RAM_RW,
   output logic [ADDRESS_WIDTH-1:0] ADDRESS,
   output logic [DATA_WIDTH-1:0]    BUS_OUT,
   output logic                     BUS_OE,
   input  logic [DATA_WIDTH-1:0]    BUS_IN,
   input  logic [DATA_WIDTH-1:0]    CPU_OUT,
   input  logic                     CPU_HALTED,
   input  logic                     LOG_RD,
   output logic [DATA_WIDTH-1:0]    LOG_DATA,
   output logic                     LOG_EMPTY,
   output logic                     LOG_OVF,
   output logic                     BUSY,
   output logic                     DONE,
   output logic                     ERROR,
   output logic                     TIMEOUT,
   output logic [ADDRESS_WIDTH-1:0] ERR_ADDR
);

   localparam int PTR_W = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;
   localparam int CNT_W = (RUN_LIMIT > 1) ? $clog2(RUN_LIMIT) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_VERIFY,
      S_RUN,
      S_DONE,
      S_ERROR
   } state_t;

   state_t state, state_nxt;

   // Control state
   logic [LEN_WIDTH-1:0]     idx;
   logic [LEN_WIDTH-1:0]     len_q;
   logic                     verify_q;
   logic [CNT_W-1:0]         run_cnt;
   logic                     timeout_q;
   logic [ADDRESS_WIDTH-1:0] err_addr_q;
   logic                     vld_p1;

   // Datapath registers
   logic [DATA_WIDTH-1:0]    exp_p1;
   logic [ADDRESS_WIDTH-1:0] addr_p1;
   logic [DATA_WIDTH-1:0]    prev_out_p1;

   // Log FIFO
   logic [DATA_WIDTH-1:0]    log_mem [LOG_DEPTH];
   logic [PTR_W-1:0]         wr_ptr, rd_ptr;
   logic [PTR_W:0]           log_cnt;
   logic                     ovf_q;

   // Combinational strobes
   logic                     accept;
   logic                     last_word;
   logic                     rd_issue;
   logic                     mismatch;
   logic                     set_timeout;
   logic [ADDRESS_WIDTH-1:0] cur_addr;
   logic                     push_req, push, pop, drop, log_full;

   // RAM address of image word i; wraps at ADDRESS_WIDTH.
   function automatic logic [ADDRESS_WIDTH-1:0] ram_addr(input logic [LEN_WIDTH-1:0] i);
      return BASE_ADDR + ADDRESS_WIDTH'(i);
   endfunction

   assign cur_addr = ram_addr(idx);
   assign mismatch = vld_p1 && (BUS_IN != exp_p1);

   // State register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next state and bus outputs
   always_comb begin
      state_nxt   = state;
      accept      = 1'b0;
      last_word   = 1'b0;
      rd_issue    = 1'b0;
      set_timeout = 1'b0;
      HALT        = 1'b1;
      EXT_RAM_EN  = 1'b1;
      EXT_RAM_RW  = 1'b0;
      BUS_OE      = 1'b0;
      BUS_OUT     = '0;
      BUSY        = 1'b0;
      case (state)
         S_IDLE, S_DONE, S_ERROR: begin
            if (START) begin
               accept    = 1'b1;
               state_nxt = (PROG_LEN == '0) ? S_RUN : S_WRITE;
            end
         end
         S_WRITE: begin
            BUSY       = 1'b1;
            EXT_RAM_RW = 1'b1;
            BUS_OE     = 1'b1;
            BUS_OUT    = PROG_DATA;
            last_word  = (idx == len_q - LEN_WIDTH'(1));
            if (last_word) state_nxt = verify_q ? S_VERIFY : S_RUN;
         end
         S_VERIFY: begin
            // Reads go out for idx < len; the extra final cycle only
            // compares the last word.
            BUSY     = 1'b1;
            rd_issue = (idx < len_q);
            if (mismatch)            state_nxt = S_ERROR;
            else if (idx == len_q)   state_nxt = S_RUN;
         end
         S_RUN: begin
            BUSY       = 1'b1;
            HALT       = 1'b0;
            EXT_RAM_EN = 1'b0;
            // A halt in the limit cycle wins over the timeout.
            if (CPU_HALTED) begin
               state_nxt = S_DONE;
            end else if (run_cnt == CNT_W'(RUN_LIMIT - 1)) begin
               state_nxt   = S_DONE;
               set_timeout = 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Control registers
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         idx        <= '0;
         len_q      <= '0;
         verify_q   <= 1'b0;
         run_cnt    <= '0;
         timeout_q  <= 1'b0;
         err_addr_q <= '0;
         vld_p1     <= 1'b0;
      end else begin
         vld_p1  <= 1'b0;
         run_cnt <= (state == S_RUN) ? run_cnt + CNT_W'(1) : '0;
         case (state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (accept) begin
                  len_q      <= PROG_LEN;
                  verify_q   <= VERIFY_EN;
                  idx        <= '0;
                  timeout_q  <= 1'b0;
                  err_addr_q <= '0;
               end
            end
            S_WRITE: begin
               idx <= last_word ? '0 : idx + LEN_WIDTH'(1);
            end
            S_VERIFY: begin
               idx    <= (state_nxt == S_VERIFY) ? idx + LEN_WIDTH'(1) : '0;
               vld_p1 <= (state_nxt == S_VERIFY) && rd_issue;
               if (mismatch) err_addr_q <= addr_p1;
            end
            S_RUN: begin
               if (set_timeout) timeout_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Stage p1: expected word/address of the read issued this cycle, and the
   // previous CPU_OUT for change detection.
   always_ff @(posedge CLK) begin
      exp_p1      <= PROG_DATA;
      addr_p1     <= cur_addr;
      prev_out_p1 <= CPU_OUT;
      if (push) log_mem[wr_ptr] <= CPU_OUT;
   end

   // The first RUN cycle (run_cnt == 0) only primes prev_out_p1.
   assign push_req = (state == S_RUN) && (run_cnt != '0) && (CPU_OUT != prev_out_p1);
   assign log_full = (log_cnt == (PTR_W+1)'(LOG_DEPTH));
   assign pop      = LOG_RD && (log_cnt != '0);
   assign push     = push_req && (!log_full || pop);
   assign drop     = push_req && log_full && !pop;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         log_cnt <= '0;
         ovf_q   <= 1'b0;
      end else if (accept) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         log_cnt <= '0;
         ovf_q   <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   log_cnt <= log_cnt + (PTR_W+1)'(1);
            2'b01:   log_cnt <= log_cnt - (PTR_W+1)'(1);
            default: log_cnt <= log_cnt;
         endcase
         if (drop) ovf_q <= 1'b1;
      end
   end

   assign PROG_ADDR = idx;
   assign ADDRESS   = cur_addr;
   assign LOG_DATA  = log_mem[rd_ptr];
   assign LOG_EMPTY = (log_cnt == '0);
   assign LOG_OVF   = ovf_q;
   assign DONE      = (state == S_DONE);
   assign ERROR     = (state == S_ERROR);
   assign TIMEOUT   = timeout_q;
   assign ERR_ADDR  = err_addr_q;

endmodule

// File: tb/tb_bat_amateur_loader.sv
// Testbench for bat_amateur_loader: RAM and image-source environment, and a
// queue-based model of the OUT-capture log and the load/verify/run timeline.
module tb_bat_amateur_loader;

   localparam int DW    = 16;
   localparam int AW    = 16;
   localparam int LW    = 8;
   localparam int BASE  = 32'h0100;
   localparam int DEPTH = 4;
   localparam int LIMIT = 10;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          verify_en;
   logic [LW-1:0] prog_len;
   logic [LW-1:0] prog_addr;
   logic [DW-1:0] prog_data;
   logic          halt;
   logic          ext_ram_en;
   logic          ext_ram_rw;
   logic [AW-1:0] address;
   logic [DW-1:0] bus_out;
   logic          bus_oe;
   logic [DW-1:0] bus_in;
   logic [DW-1:0] cpu_out;
   logic          cpu_halted;
   logic          log_rd;
   logic [DW-1:0] log_data;
   logic          log_empty;
   logic          log_ovf;
   logic          busy;
   logic          done;
   logic          error;
   logic          timeout;
   logic [AW-1:0] err_addr;

   bat_amateur_loader #(
      .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .LEN_WIDTH(LW),
      .BASE_ADDR(16'h0100), .LOG_DEPTH(DEPTH), .RUN_LIMIT(LIMIT)
   ) dut (
      .CLK(clk), .RST(rst), .START(start), .VERIFY_EN(verify_en),
      .PROG_LEN(prog_len), .PROG_ADDR(prog_addr), .PROG_DATA(prog_data),
      .HALT(halt), .EXT_RAM_EN(ext_ram_en), .EXT_RAM_RW(ext_ram_rw),
      .ADDRESS(address), .BUS_OUT(bus_out), .BUS_OE(bus_oe), .BUS_IN(bus_in),
      .CPU_OUT(cpu_out), .CPU_HALTED(cpu_halted), .LOG_RD(log_rd),
      .LOG_DATA(log_data), .LOG_EMPTY(log_empty), .LOG_OVF(log_ovf),
      .BUSY(busy), .DONE(done), .ERROR(error), .TIMEOUT(timeout),
      .ERR_ADDR(err_addr)
   );

   always #5 clk = ~clk;

   // Image source and external RAM with one-cycle read latency; a selected
   // address can be corrupted on read.
   logic [DW-1:0] img [0:255];
   logic [DW-1:0] ram [0:65535];
   logic          corrupt_en;
   logic [AW-1:0] corrupt_addr;

   assign prog_data = img[prog_addr];

   always @(posedge clk) begin
      if (ext_ram_en && ext_ram_rw) ram[address] <= bus_out;
      bus_in <= ram[address] ^ ((corrupt_en && address == corrupt_addr) ? 16'h0040 : 16'h0000);
   end

   // Log model
   logic [DW-1:0] q [$];
   logic          ovf_m;
   logic [DW-1:0] prev_m;

   // Per-run stimulus
   logic [DW-1:0] outs [0:LIMIT-1];
   logic          rds  [0:LIMIT-1];
   logic [DW-1:0] exp_cap [0:2];

   int vectors    = 0;
   int miscompares = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_log(input string tag);
      chk({tag, ".empty"}, 32'(log_empty), 32'(q.size() == 0));
      if (q.size() != 0) chk({tag, ".data"}, 32'(log_data), 32'(q[0]));
      chk({tag, ".ovf"}, 32'(log_ovf), 32'(ovf_m));
   endtask

   task automatic do_start(input int len, input logic ver);
      prog_len  = LW'(len);
      verify_en = ver;
      start     = 1'b1;
      step();
      start = 1'b0;
      q.delete();
      ovf_m = 1'b0;
      chk("start.busy", 32'(busy), 32'd1);
      chk("start.timeout", 32'(timeout), 32'd0);
      chk("start.err_addr", 32'(err_addr), 32'd0);
      chk_log("start.log");
   endtask

   task automatic check_write(input int len);
      for (int k = 0; k < len; k++) begin
         chk("wr.busy", 32'(busy), 32'd1);
         chk("wr.halt", 32'(halt), 32'd1);
         chk("wr.en", 32'(ext_ram_en), 32'd1);
         chk("wr.rw", 32'(ext_ram_rw), 32'd1);
         chk("wr.oe", 32'(bus_oe), 32'd1);
         chk("wr.addr", 32'(address), 32'(BASE + k));
         chk("wr.prog_addr", 32'(prog_addr), 32'(k));
         chk("wr.data", 32'(bus_out), 32'(img[k]));
         // A START during the load must be ignored.
         if (k == 0 && len > 1) begin start = 1'b1; prog_len = '0; end
         if (k == 1) start = 1'b0;
         step();
      end
      start = 1'b0;
   endtask

   task automatic check_verify(input int len, input int bad);
      int n;
      n = (bad >= 0) ? bad + 2 : len + 1;
      for (int c = 0; c < n; c++) begin
         chk("vf.busy", 32'(busy), 32'd1);
         chk("vf.halt", 32'(halt), 32'd1);
         chk("vf.rw", 32'(ext_ram_rw), 32'd0);
         chk("vf.oe", 32'(bus_oe), 32'd0);
         chk("vf.en", 32'(ext_ram_en), 32'd1);
         if (c < len) chk("vf.addr", 32'(address), 32'(BASE + c));
         step();
      end
      if (bad >= 0) begin
         chk("vf.error", 32'(error), 32'd1);
         chk("vf.err_addr", 32'(err_addr), 32'(BASE + bad));
         chk("vf.err_halt", 32'(halt), 32'd1);
         chk("vf.err_busy", 32'(busy), 32'd0);
      end else begin
         chk("vf.run_halt", 32'(halt), 32'd0);
         chk("vf.run_busy", 32'(busy), 32'd1);
      end
   endtask

   task automatic do_run(input int halt_at);
      logic pop_m, push_m, full_m;
      for (int n = 0; n < LIMIT; n++) begin
         chk("run.busy", 32'(busy), 32'd1);
         chk("run.halt", 32'(halt), 32'd0);
         chk("run.en", 32'(ext_ram_en), 32'd0);
         chk("run.oe", 32'(bus_oe), 32'd0);
         cpu_out    = outs[n];
         cpu_halted = (n == halt_at);
         log_rd     = rds[n];
         pop_m  = log_rd && (q.size() > 0);
         push_m = (n > 0) && (outs[n] != prev_m);
         full_m = (q.size() == DEPTH);
         if (pop_m) void'(q.pop_front());
         if (push_m) begin
            if (!full_m || pop_m) q.push_back(outs[n]);
            else                  ovf_m = 1'b1;
         end
         prev_m = outs[n];
         step();
         chk_log("run.log");
         if (n == halt_at || n == LIMIT - 1) begin
            chk("end.done", 32'(done), 32'd1);
            chk("end.busy", 32'(busy), 32'd0);
            chk("end.halt", 32'(halt), 32'd1);
            chk("end.en", 32'(ext_ram_en), 32'd1);
            chk("end.timeout", 32'(timeout), 32'(n != halt_at));
            break;
         end
      end
      cpu_halted = 1'b0;
      log_rd     = 1'b0;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < DEPTH && q.size() > 0; i++) begin
         chk({tag, ".head"}, 32'(log_data), 32'(q[0]));
         log_rd = 1'b1;
         step();
         log_rd = 1'b0;
         void'(q.pop_front());
         chk_log(tag);
      end
      // Pop on an empty log is ignored.
      log_rd = 1'b1;
      step();
      log_rd = 1'b0;
      chk_log({tag, ".empty_rd"});
   endtask

   task automatic fill_outs_const(input logic [DW-1:0] v);
      for (int i = 0; i < LIMIT; i++) begin outs[i] = v; rds[i] = 1'b0; end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int len, bad;
      logic ver;
      rst = 1'b1; start = 1'b0; verify_en = 1'b0; prog_len = '0;
      cpu_out = '0; cpu_halted = 1'b0; log_rd = 1'b0;
      corrupt_en = 1'b0; corrupt_addr = '0;
      ovf_m = 1'b0; prev_m = '0;
      exp_cap[0] = 16'h5; exp_cap[1] = 16'h7; exp_cap[2] = 16'h9;
      for (int i = 0; i < 256; i++) img[i] = '0;

      // Reset state
      step(); step();
      rst = 1'b0;
      step();
      chk("rst.halt", 32'(halt), 32'd1);
      chk("rst.en", 32'(ext_ram_en), 32'd1);
      chk("rst.rw", 32'(ext_ram_rw), 32'd0);
      chk("rst.oe", 32'(bus_oe), 32'd0);
      chk("rst.addr", 32'(address), 32'(BASE));
      chk("rst.bus_out", 32'(bus_out), 32'd0);
      chk("rst.prog_addr", 32'(prog_addr), 32'd0);
      chk("rst.err_addr", 32'(err_addr), 32'd0);
      chk("rst.empty", 32'(log_empty), 32'd1);
      chk("rst.ovf", 32'(log_ovf), 32'd0);
      chk("rst.timeout", 32'(timeout), 32'd0);
      chk("rst.done", 32'(done), 32'd0);
      chk("rst.error", 32'(error), 32'd0);
      chk("rst.busy", 32'(busy), 32'd0);

      // Load without verify, then capture 0,0,5,5,7,7,7,9
      img[0] = 16'h1111; img[1] = 16'h2222; img[2] = 16'h3333; img[3] = 16'h4444;
      do_start(4, 1'b0);
      check_write(4);
      chk("load.halt_fall", 32'(halt), 32'd0);
      for (int k = 0; k < 4; k++) chk("load.ram", 32'(ram[BASE + k]), 32'(img[k]));
      outs[0] = 16'h0; outs[1] = 16'h0; outs[2] = 16'h5; outs[3] = 16'h5;
      outs[4] = 16'h7; outs[5] = 16'h7; outs[6] = 16'h7; outs[7] = 16'h9;
      outs[8] = 16'h9; outs[9] = 16'h9;
      for (int i = 0; i < LIMIT; i++) rds[i] = 1'b0;
      do_run(8);
      for (int i = 0; i < 3; i++) begin
         chk("cap.data", 32'(log_data), 32'(exp_cap[i]));
         log_rd = 1'b1;
         step();
         log_rd = 1'b0;
         void'(q.pop_front());
      end
      chk("cap.empty", 32'(log_empty), 32'd1);

      // Verify with a corrupted word at 0x0102
      corrupt_en = 1'b1; corrupt_addr = 16'h0102;
      do_start(4, 1'b1);
      check_write(4);
      check_verify(4, 2);
      step();
      chk("err.hold", 32'(error), 32'd1);
      chk("err.hold_halt", 32'(halt), 32'd1);
      corrupt_en = 1'b0;

      // Verify pass, restarted from ERROR
      do_start(4, 1'b1);
      check_write(4);
      check_verify(4, -1);
      fill_outs_const(16'h0);
      do_run(0);

      // Overflow and push/pop while full
      do_start(0, 1'b0);
      for (int i = 0; i < LIMIT; i++) begin
         outs[i] = (i < 8) ? DW'(i + 1) : 16'h8;
         rds[i]  = (i == 7);
      end
      do_run(8);
      chk("ovf.flag", 32'(log_ovf), 32'd1);
      chk("ovf.head", 32'(log_data), 32'h3);
      drain("ovf.drain");

      // Timeout, then halt on the limit cycle
      do_start(0, 1'b0);
      fill_outs_const(16'h0);
      do_run(-1);
      chk("to.timeout", 32'(timeout), 32'd1);
      do_start(0, 1'b0);
      do_run(LIMIT - 1);
      chk("to.halt_wins", 32'(timeout), 32'd0);

      // Reset during word 2 of a load
      do_start(4, 1'b0);
      step(); step();
      chk("rw.addr2", 32'(address), 32'(BASE + 2));
      rst = 1'b1;
      #1;
      chk("rw.halt", 32'(halt), 32'd1);
      chk("rw.oe", 32'(bus_oe), 32'd0);
      chk("rw.busy", 32'(busy), 32'd0);
      chk("rw.rw", 32'(ext_ram_rw), 32'd0);
      step();
      rst = 1'b0;
      q.delete(); ovf_m = 1'b0;
      step();
      chk_log("rw.log");
      do_start(0, 1'b0);
      chk("rw.run", 32'(halt), 32'd0);
      fill_outs_const(16'h0);
      do_run(0);

      // Randomized load / verify / run
      for (int it = 0; it < 8; it++) begin
         len = $urandom_range(1, 12);
         for (int k = 0; k < len; k++) img[k] = DW'($urandom);
         ver = 1'($urandom_range(0, 1));
         bad = (ver && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, len - 1)) : -1;
         corrupt_en   = (bad >= 0);
         corrupt_addr = AW'(BASE + ((bad >= 0) ? bad : 0));
         do_start(len, ver);
         check_write(len);
         for (int k = 0; k < len; k++) chk("rnd.ram", 32'(ram[BASE + k]), 32'(img[k]));
         if (ver) check_verify(len, bad);
         if (bad < 0) begin
            for (int i = 0; i < LIMIT; i++) begin
               outs[i] = DW'($urandom_range(0, 3));
               rds[i]  = ($urandom_range(0, 3) == 0);
            end
            do_run(int'($urandom_range(0, 12)));
            drain("rnd.drain");
         end
         corrupt_en = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
